// File: rtl/gen_lane_serializer.sv
// Parallel-to-serial lane emitter: one COUNT-lane frame out as ordered beats.
// Optional out_par port when GEN_LANE_SERIALIZER_PARITY_EN is defined.
module gen_lane_serializer #(
  parameter int COUNT = 10,
  parameter int WIDTH = 8,
  localparam int IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [COUNT*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_last,
`ifdef GEN_LANE_SERIALIZER_PARITY_EN
  output logic                   out_par,
`endif
  output logic                   busy
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(COUNT - 1);

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [COUNT*WIDTH-1:0] frame;
  logic [WIDTH-1:0]       lane;
  logic                   act;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      frame <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            frame <= in_data;
            idx   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (idx == LAST) begin
              idx   <= '0;
              state <= IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    lane = '0;
    for (int k = 0; k < COUNT; k++) begin
      if (idx == IDX_W'(k)) lane = frame[k*WIDTH +: WIDTH];
    end
  end

  // Reset gates every output immediately, not just from the next edge.
  assign act       = (state == SEND) && !rst;
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = act;
  assign busy      = act;
  assign out_data  = act ? lane : '0;
  assign out_idx   = act ? idx : '0;
  assign out_last  = act && (idx == LAST);

`ifdef GEN_LANE_SERIALIZER_PARITY_EN
  assign out_par = ^out_data;
`endif

endmodule

// File: tb/tb_gen_lane_serializer.sv
// Bench for gen_lane_serializer: directed cases plus random traffic
// checked against a queue-based lane model.
module tb_gen_lane_serializer;

  localparam int C = 10;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [C*W-1:0] in_data;
  logic [W-1:0] out_data;
  logic [3:0]   out_idx;

  logic         rst1, v1, rdy1, ov1, ordy1, last1, busy1;
  logic [W-1:0] d1, od1;
  logic [0:0]   idx1;

`ifdef GEN_LANE_SERIALIZER_PARITY_EN
  logic par, par1;
`endif

  gen_lane_serializer #(.COUNT(C), .WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
`ifdef GEN_LANE_SERIALIZER_PARITY_EN
    .out_par(par),
`endif
    .busy(busy)
  );

  gen_lane_serializer #(.COUNT(1), .WIDTH(W)) u_one (
    .clk(clk), .rst(rst1), .in_valid(v1), .in_ready(rdy1),
    .in_data(d1), .out_valid(ov1), .out_ready(ordy1),
    .out_data(od1), .out_idx(idx1), .out_last(last1),
`ifdef GEN_LANE_SERIALIZER_PARITY_EN
    .out_par(par1),
`endif
    .busy(busy1)
  );

  int total = 0;
  int bad = 0;
  logic [W-1:0] q[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [C*W-1:0] mk(input logic [W-1:0] base);
    logic [C*W-1:0] f;
    f = '0;
    for (int k = 0; k < C; k++) f[k*W +: W] = base + W'(k);
    return f;
  endfunction

  // One clock: drive, check against the queue model, advance model.
  task automatic cyc(input logic v, input logic [C*W-1:0] d,
                     input logic ordy, input logic r);
    logic ev;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    rst       = r;
    #2;
    ev = !r && (q.size() != 0);
    chk("in_ready", 64'(in_ready), 64'(!r && q.size() == 0));
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("busy", 64'(busy), 64'(ev));
    chk("out_data", 64'(out_data), ev ? 64'(q[0]) : 64'd0);
    chk("out_idx", 64'(out_idx), ev ? 64'(C - q.size()) : 64'd0);
    chk("out_last", 64'(out_last), 64'(ev && q.size() == 1));
`ifdef GEN_LANE_SERIALIZER_PARITY_EN
    chk("out_par", 64'(par), ev ? 64'(^q[0]) : 64'd0);
`endif
    if (r) q.delete();
    else if (q.size() == 0 && v)
      for (int k = 0; k < C; k++) q.push_back(d[k*W +: W]);
    else if (q.size() != 0 && ordy) void'(q.pop_front());
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [C*W-1:0] fa, fb, rnd;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    rst1 = 1'b1; v1 = 1'b0; d1 = '0; ordy1 = 1'b0;
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    cyc(1'b1, mk(8'h10), 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0);

    fa = mk(8'h10);
    cyc(1'b1, fa, 1'b1, 1'b0);
    for (int i = 0; i < C; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);

    cyc(1'b1, fa, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, '0, 1'b1, 1'b0);

    fb = mk(8'h80);
    cyc(1'b1, fa, 1'b1, 1'b0);
    for (int i = 0; i < C + 2; i++) cyc(1'b1, fb, 1'b1, 1'b0);
    for (int i = 0; i < C; i++) cyc(1'b0, '0, 1'b1, 1'b0);

    cyc(1'b1, fa, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b1, fb, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++) begin
      rnd = {$urandom, $urandom, $urandom};
      cyc(1'($urandom_range(0, 1)), rnd, 1'($urandom_range(0, 2) != 0),
          $urandom_range(0, 40) == 0);
    end

    // Single-lane instance.
    v1 = 1'b1; d1 = 8'hA5; ordy1 = 1'b1;
    #2;
    chk("one_rdy", 64'(rdy1), 64'd1);
    @(posedge clk);
    #1;
    v1 = 1'b0; d1 = 8'h00;
    #2;
    chk("one_valid", 64'(ov1), 64'd1);
    chk("one_data", 64'(od1), 64'hA5);
    chk("one_idx", 64'(idx1), 64'd0);
    chk("one_last", 64'(last1), 64'd1);
`ifdef GEN_LANE_SERIALIZER_PARITY_EN
    chk("one_par_a5", 64'(par1), 64'd0);
`endif
    @(posedge clk);
    #1;
    v1 = 1'b1; d1 = 8'h07;
    #2;
    chk("one_valid_done", 64'(ov1), 64'd0);
    chk("one_rdy_again", 64'(rdy1), 64'd1);
    chk("one_idle_data", 64'(od1), 64'd0);
    @(posedge clk);
    #1;
    v1 = 1'b0;
    #2;
    chk("one_data_07", 64'(od1), 64'h07);
    chk("one_busy", 64'(busy1), 64'd1);
`ifdef GEN_LANE_SERIALIZER_PARITY_EN
    chk("one_par_07", 64'(par1), 64'd1);
`endif
    @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
